uart_rx: RTL and testbench
==========================

# uart_rx

Byte receiver for the processor core's serial port: recovers 8N1 frames from the asynchronous `rx` pin and delivers each byte through a single-entry valid/ready holding register to the core's I/O logic. It is the receiving end of the core's UART link, the counterpart of the transmitter that drives `tx`. It also flags framing errors and dropped bytes.

## Interface
- `CLK_FREQ`, 50000000: `clk` frequency in Hz.
- `BAUD`, 115200: line rate. Derived values: `DIV = CLK_FREQ/BAUD` (integer division; 434 at defaults) and `HALF = DIV/2` (217).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `data`  out  8  received byte; stable while `valid`=1.
- `valid`  out  1  holding register full.
- `ready`  in  1  consumer accepts the held byte when `valid`&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a good byte completed while the holding register was full; that byte is dropped.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: two flops, both reset to 1. Every reference to `rx_s` below means the second flop's output.
- Bit counter width: ceil(log2(DIV)). Bit index: 3 bits. Shift register: 8 bits, LSB-first, each new bit shifted in at bit 7.
- IDLE:
  - `rx_s`=0 → START, counter cleared.
- START:
  - Count HALF cycles, then sample `rx_s`.
  - Sample 1 → IDLE. This is glitch rejection; no flags are raised.
  - Sample 0 → DATA, with counter and bit index cleared.
- DATA:
  - Count DIV cycles, then sample `rx_s` into the shift register.
  - After the 8th sample → STOP.
- STOP: count DIV cycles, then sample `rx_s`.
  - Sample 1 → IDLE, and deliver the byte as follows:
    - If `valid`=0, or `valid`&`ready` in this cycle: `data` loads the byte and `valid`=1 on the next edge.
    - Otherwise: `overrun` pulses, and `data`/`valid` are unchanged.
  - Sample 0 → BREAK, `frame_err` pulses, byte discarded.
- BREAK:
  - Wait for `rx_s`=1, then → IDLE.
  - A held-low line produces exactly one `frame_err`, not repeated ones.
- Holding register:
  - `valid`&`ready` with no simultaneous load → `valid`=0 on the next edge.
  - A load in the same cycle as acceptance → `valid` stays 1 and `data` takes the new byte; no `overrun`.
  - `data` is never modified while `valid`=1, except by a load that coincides with acceptance.

## Timing
- Reset values:
  - State IDLE; counter, bit index and shift register at 0.
  - Synchronizer flops at 1.
  - `data`=0x00; `valid`, `frame_err`, `overrun`, `busy` all 0.
- Reset mid-frame discards the partial byte and any held byte. After release, the receiver waits in IDLE for the next falling edge; a line that is already low counts as a start.
- Latency: let T be the edge at which IDLE sees `rx_s`=0.
  - Start-bit sample at T+HALF.
  - Data bit k (k=0..7) sampled at T+HALF+(k+1)·DIV.
  - Stop sample at T+HALF+9·DIV.
  - `valid`/`frame_err`/`overrun` are visible one cycle after the stop sample.
- Pin-to-T delay is 2–3 cycles (synchronizer).
- Back-to-back frames:
  - The state machine is back in IDLE one cycle after the stop sample, so the next start edge, arriving HALF cycles later at nominal baud, is caught.
  - Tolerated baud mismatch is ±4% (sampling stays within the mid 80% of each bit over 10 bits).
- `busy` rises the cycle after T and falls the cycle after the stop sample, or on leaving BREAK.

## Test plan
Bench parameters: `CLK_FREQ`=1600000, `BAUD`=100000 (DIV=16, HALF=8). All frames are driven at exactly 16 clk per bit.
- Reset: assert `rst` mid-frame, hold `rx`=1 → all outputs 0, `busy`=0; the next frame 0xA5 is received correctly.
- Single frame 0xA5, `ready`=0 → `valid` rises one cycle after T+152 with `data`=0xA5; `ready` pulsed for 1 cycle → `valid`=0 on the next edge.
- Glitch: `rx` low for 4 cycles, then high → no `valid`, `frame_err` or `overrun`; `busy` high for 8 cycles, then back in IDLE.
- Framing/break: frame 0x3C with stop bit 0, then `rx` held low for 200 cycles → exactly one `frame_err` pulse, no `valid`; the following frame 0x81 is received correctly.
- Overrun: frames 0x11 then 0x22 back-to-back, `ready`=0 → `data`=0x11, `valid`=1, and one `overrun` pulse at the second stop. Repeat with `ready`=1 exactly in the second load cycle → `data`=0x22, `valid`=1, no `overrun`.
- Stream: 256 back-to-back frames 0x00..0xFF with `ready`=1 → every byte delivered in order, no error pulses; repeat at ±3% bit length → identical results.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial byte receiver with a single-entry valid/ready holding register.
//
// Parameters:
//   CLK_FREQ  clk frequency in Hz
//   BAUD      line rate; DIV = CLK_FREQ/BAUD clocks per bit, HALF = DIV/2
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial line, asynchronous to clk, idle high
//   data       received byte, stable while valid is high
//   valid      holding register full
//   ready      consumer takes the held byte when valid & ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: good byte dropped because the holding register was full
//   busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] DivLast  = CW'(DIV - 1);
    localparam logic [CW-1:0] HalfLast = CW'(HALF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e        state_q;
    logic          rx_meta_q;
    logic          rx_s;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          accept;

    assign accept = valid & ready;

    // Two-flop synchronizer; both flops reset to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Acceptance empties the register; a load in the stop state below overrides this.
            if (accept) begin
                valid <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                    end
                end

                StStart: begin
                    if (cnt_q == HalfLast) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // Start bit gone at mid-bit: treat as a glitch, no flags.
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                StData: begin
                    if (cnt_q == DivLast) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= StStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                StStop: begin
                    if (cnt_q == DivLast) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            if (!valid || accept) begin
                                data  <= shift_q;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            state_q   <= StBreak;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                StBreak: begin
                    // Parked until the line returns high, so a held-low line flags only once.
                    if (rx_s) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUD     = 100000;
    localparam realtime BIT_NOM  = 160.0;
    localparam realtime BIT_FAST = 155.2;
    localparam realtime BIT_SLOW = 164.8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         fe0;
    int         ov0;
    int         busy_cnt;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       vprev = 1'b0;
    logic       acc_prev = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: a byte is presented when valid is high and the register was either empty or
    // accepted on the previous edge.
    always @(negedge clk) begin
        if (rst) begin
            vprev    <= 1'b0;
            acc_prev <= 1'b0;
        end else begin
            if (valid && (!vprev || acc_prev)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("sb_data", 32'(data), 32'(mon_exp));
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            vprev    <= valid;
            acc_prev <= valid & ready;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready();
        align();
        ready = 1'b1;
        wait_cycles(1);
        ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input realtime bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bt);
        end
        rx = stop_bit;
        #(bt);
    endtask

    task automatic stream(input int first, input int step, input int count, input realtime bt,
                          input string tag);
        logic [7:0] b;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        align();
        ready = 1'b1;
        for (int i = 0; i < count; i++) begin
            b = 8'(first + i * step);
            exp_q.push_back(b);
            send_frame(b, 1'b1, bt);
        end
        wait_cycles(10);
        ready = 1'b0;
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
        check({tag, "_frame_err"}, 32'(fe_cnt - fe0), 0);
        check({tag, "_overrun"}, 32'(ov_cnt - ov0), 0);
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        align();
        rst = 1'b0;
        wait_cycles(5);

        // Held byte, then reset mid-frame discards both
        exp_q.push_back(8'h5A);
        align();
        send_frame(8'h5A, 1'b1, BIT_NOM);
        wait_cycles(5);
        check("held_valid", 32'(valid), 1);
        rx = 1'b0;
        wait_cycles(60);
        check("busy_mid_frame", 32'(busy), 1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(valid), 0);
        check("midrst_data", 32'(data), 0);
        check("midrst_busy", 32'(busy), 0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(5);

        // Single frame latency: valid visible right after edge T+152, T = start + 3 edges
        exp_q.push_back(8'hA5);
        align();
        fork
            send_frame(8'hA5, 1'b1, BIT_NOM);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                check("lat_valid_before", 32'(valid), 0);
                @(negedge clk);
                check("lat_valid", 32'(valid), 1);
                check("lat_data", 32'(data), 32'h A5);
            end
        join
        wait_cycles(3);
        check("hold_valid", 32'(valid), 1);
        pulse_ready();
        @(negedge clk);
        check("accept_clears_valid", 32'(valid), 0);

        // Glitch: 4-cycle low pulse
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        align();
        fork
            begin
                rx = 1'b0;
                #40;
                rx = 1'b1;
            end
            begin
                busy_cnt = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (busy) busy_cnt++;
                end
            end
        join
        check("glitch_busy_cycles", 32'(busy_cnt), 8);
        check("glitch_busy_end", 32'(busy), 0);
        check("glitch_valid", 32'(valid), 0);
        check("glitch_frame_err", 32'(fe_cnt - fe0), 0);
        check("glitch_overrun", 32'(ov_cnt - ov0), 0);

        // Framing error followed by a long break
        fe0 = fe_cnt;
        align();
        send_frame(8'h3C, 1'b0, BIT_NOM);
        wait_cycles(200);
        rx = 1'b1;
        wait_cycles(20);
        check("break_frame_err", 32'(fe_cnt - fe0), 1);
        check("break_valid", 32'(valid), 0);
        check("break_busy", 32'(busy), 0);
        exp_q.push_back(8'h81);
        align();
        send_frame(8'h81, 1'b1, BIT_NOM);
        wait_cycles(5);
        check("after_break_valid", 32'(valid), 1);
        pulse_ready();
        check("after_break_drained", 32'(exp_q.size()), 0);

        // Overrun: second byte dropped while first is held
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        align();
        send_frame(8'h11, 1'b1, BIT_NOM);
        send_frame(8'h22, 1'b1, BIT_NOM);
        wait_cycles(5);
        check("ovr_pulses", 32'(ov_cnt - ov0), 1);
        check("ovr_valid", 32'(valid), 1);
        check("ovr_data", 32'(data), 32'h11);
        pulse_ready();
        @(negedge clk);
        check("ovr_cleared", 32'(valid), 0);

        // Acceptance coincident with the second load: no overrun, new byte replaces old
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        align();
        fork
            begin
                send_frame(8'h11, 1'b1, BIT_NOM);
                send_frame(8'h22, 1'b1, BIT_NOM);
            end
            begin
                // Second frame starts 160 edges in; its stop sample is 155 edges later.
                repeat (314) @(posedge clk);
                #1;
                ready = 1'b1;
                @(posedge clk);
                #1;
                ready = 1'b0;
            end
        join
        wait_cycles(5);
        check("swap_overrun", 32'(ov_cnt - ov0), 0);
        check("swap_valid", 32'(valid), 1);
        check("swap_data", 32'(data), 32'h22);
        pulse_ready();
        @(negedge clk);
        check("swap_cleared", 32'(valid), 0);
        check("swap_drained", 32'(exp_q.size()), 0);

        // Streams: nominal, 3% fast, 3% slow
        stream(0, 1, 256, BIT_NOM, "stream_nom");
        stream(0, 3, 86, BIT_FAST, "stream_fast");
        stream(1, 3, 86, BIT_SLOW, "stream_slow");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
